// File: rtl/pri_irq_ctrl.sv
// Eight-input interrupt controller: edge capture into a pending register, fixed priority
// arbitration (bit 7 highest) under a mask, and a raise/ack/eoi handshake to the processor.
module pri_irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mask_we,
  input  logic [7:0] mask_din,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] vec,
  output logic       busy,
  output logic [7:0] pend,
  output logic [7:0] isr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] req_q;
  logic [7:0] mask;
  logic [7:0] req_edge;
  logic [7:0] cand;
  logic [7:0] grant;
  logic [7:0] clr;
  logic [2:0] grant_idx;
  logic       any;

  assign req_edge = req & ~req_q;
  assign cand     = pend & ~mask;
  assign any      = |cand;
  assign clr      = (state == PEND && ack) ? (8'd1 << vec) : 8'd0;

  // Ascending scan: the last set bit seen is the highest, so it wins the grant.
  always_comb begin
    grant     = 8'd0;
    grant_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) begin
        grant     = 8'd1 << i;
        grant_idx = 3'(i);
      end
    end
  end

  // Set is OR-ed in after the clear so a coincident new edge keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 8'd0;
      pend  <= 8'd0;
      mask  <= 8'd0;
    end else begin
      req_q <= req;
      pend  <= (pend & ~clr) | req_edge;
      if (mask_we) begin
        mask <= mask_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      irq   <= 1'b0;
      vec   <= 3'd0;
      busy  <= 1'b0;
      isr   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            vec   <= grant_idx;
            irq   <= 1'b1;
            state <= PEND;
          end
        end
        // vec stays frozen here: no preemption, and masking does not withdraw irq.
        PEND: begin
          if (ack) begin
            isr   <= 8'd1 << vec;
            irq   <= 1'b0;
            busy  <= 1'b1;
            state <= SERV;
          end
        end
        SERV: begin
          if (eoi) begin
            isr   <= 8'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          busy  <= 1'b0;
          isr   <= 8'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pri_irq_ctrl.sv
// Directed scoreboard bench for pri_irq_ctrl: each step pushes the expected registered
// outputs for the next edge, then pops and compares them one cycle later.
module tb_pri_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_din;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vec;
  logic       busy;
  logic [7:0] pend;
  logic [7:0] isr;

  typedef struct packed {
    logic       irq;
    logic [2:0] vec;
    logic       busy;
    logic [7:0] pend;
    logic [7:0] isr;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    checks   = 0;
  int    failures = 0;

  pri_irq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mask_we  (mask_we),
    .mask_din (mask_din),
    .ack      (ack),
    .eoi      (eoi),
    .irq      (irq),
    .vec      (vec),
    .busy     (busy),
    .pend     (pend),
    .isr      (isr)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic i, input logic [2:0] v, input logic b,
                              input logic [7:0] p, input logic [7:0] s);
    exp_t e;
    e.irq  = i;
    e.vec  = v;
    e.busy = b;
    e.pend = p;
    e.isr  = s;
    return e;
  endfunction

  task automatic checkOutput();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty got=0 exp=1");
      return;
    end
    e = sb.pop_front();
    t = tags.pop_front();
    checks++;
    assert (irq === e.irq) else begin
      failures++;
      $error("[TB] FAIL %s.irq got=%0b exp=%0b", t, irq, e.irq);
    end
    checks++;
    assert (vec === e.vec) else begin
      failures++;
      $error("[TB] FAIL %s.vec got=%0d exp=%0d", t, vec, e.vec);
    end
    checks++;
    assert (busy === e.busy) else begin
      failures++;
      $error("[TB] FAIL %s.busy got=%0b exp=%0b", t, busy, e.busy);
    end
    checks++;
    assert (pend === e.pend) else begin
      failures++;
      $error("[TB] FAIL %s.pend got=%h exp=%h", t, pend, e.pend);
    end
    checks++;
    assert (isr === e.isr) else begin
      failures++;
      $error("[TB] FAIL %s.isr got=%h exp=%h", t, isr, e.isr);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic [7:0] rq,
                               input logic mwe, input logic [7:0] md,
                               input logic a, input logic e, input exp_t expv);
    rst      = r;
    req      = rq;
    mask_we  = mwe;
    mask_din = md;
    ack      = a;
    eoi      = e;
    sb.push_back(expv);
    tags.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; mask_we = 1'b0; mask_din = 8'h00; ack = 1'b0; eoi = 1'b0;

    applyStimulus("reset",        1, 8'h00, 0, 8'h00, 0, 0, ex(0, 3'd0, 0, 8'h00, 8'h00));
    applyStimulus("ack_in_idle",  0, 8'h00, 0, 8'h00, 1, 0, ex(0, 3'd0, 0, 8'h00, 8'h00));

    // Single request
    applyStimulus("single_set",   0, 8'h10, 0, 8'h00, 0, 0, ex(0, 3'd0, 0, 8'h10, 8'h00));
    applyStimulus("single_irq",   0, 8'h00, 0, 8'h00, 0, 0, ex(1, 3'd4, 0, 8'h10, 8'h00));
    applyStimulus("single_eoi_x", 0, 8'h00, 0, 8'h00, 0, 1, ex(1, 3'd4, 0, 8'h10, 8'h00));
    applyStimulus("single_ack",   0, 8'h00, 0, 8'h00, 1, 0, ex(0, 3'd4, 1, 8'h00, 8'h10));
    applyStimulus("single_ack_x", 0, 8'h00, 0, 8'h00, 1, 0, ex(0, 3'd4, 1, 8'h00, 8'h10));
    applyStimulus("single_eoi",   0, 8'h00, 0, 8'h00, 0, 1, ex(0, 3'd4, 0, 8'h00, 8'h00));
    applyStimulus("single_idle",  0, 8'h00, 0, 8'h00, 0, 0, ex(0, 3'd4, 0, 8'h00, 8'h00));

    // Priority order 7, 2, 0; ack+eoi together counts as ack
    applyStimulus("prio_set",     0, 8'h85, 0, 8'h00, 0, 0, ex(0, 3'd4, 0, 8'h85, 8'h00));
    applyStimulus("prio_irq7",    0, 8'h85, 0, 8'h00, 0, 0, ex(1, 3'd7, 0, 8'h85, 8'h00));
    applyStimulus("prio_ack7",    0, 8'h85, 0, 8'h00, 1, 1, ex(0, 3'd7, 1, 8'h05, 8'h80));
    applyStimulus("prio_eoi7",    0, 8'h85, 0, 8'h00, 0, 1, ex(0, 3'd7, 0, 8'h05, 8'h00));
    applyStimulus("prio_irq2",    0, 8'h85, 0, 8'h00, 0, 0, ex(1, 3'd2, 0, 8'h05, 8'h00));
    applyStimulus("prio_ack2",    0, 8'h85, 0, 8'h00, 1, 0, ex(0, 3'd2, 1, 8'h01, 8'h04));
    applyStimulus("prio_eoi2",    0, 8'h85, 0, 8'h00, 0, 1, ex(0, 3'd2, 0, 8'h01, 8'h00));
    applyStimulus("prio_irq0",    0, 8'h85, 0, 8'h00, 0, 0, ex(1, 3'd0, 0, 8'h01, 8'h00));
    applyStimulus("prio_ack0",    0, 8'h85, 0, 8'h00, 1, 0, ex(0, 3'd0, 1, 8'h00, 8'h01));
    applyStimulus("prio_eoi0",    0, 8'h85, 0, 8'h00, 0, 1, ex(0, 3'd0, 0, 8'h00, 8'h00));
    applyStimulus("prio_drop",    0, 8'h00, 0, 8'h00, 0, 0, ex(0, 3'd0, 0, 8'h00, 8'h00));

    // No preemption
    applyStimulus("npre_set",     0, 8'h02, 0, 8'h00, 0, 0, ex(0, 3'd0, 0, 8'h02, 8'h00));
    applyStimulus("npre_irq1",    0, 8'h02, 0, 8'h00, 0, 0, ex(1, 3'd1, 0, 8'h02, 8'h00));
    applyStimulus("npre_req6",    0, 8'h42, 0, 8'h00, 0, 0, ex(1, 3'd1, 0, 8'h42, 8'h00));
    applyStimulus("npre_hold",    0, 8'h42, 0, 8'h00, 0, 0, ex(1, 3'd1, 0, 8'h42, 8'h00));
    applyStimulus("npre_ack1",    0, 8'h42, 0, 8'h00, 1, 0, ex(0, 3'd1, 1, 8'h40, 8'h02));
    applyStimulus("npre_eoi1",    0, 8'h42, 0, 8'h00, 0, 1, ex(0, 3'd1, 0, 8'h40, 8'h00));
    applyStimulus("npre_irq6",    0, 8'h42, 0, 8'h00, 0, 0, ex(1, 3'd6, 0, 8'h40, 8'h00));
    applyStimulus("npre_ack6",    0, 8'h42, 0, 8'h00, 1, 0, ex(0, 3'd6, 1, 8'h00, 8'h40));
    applyStimulus("npre_eoi6",    0, 8'h00, 0, 8'h00, 0, 1, ex(0, 3'd6, 0, 8'h00, 8'h00));

    // Masking
    applyStimulus("mask_wr08",    0, 8'h00, 1, 8'h08, 0, 0, ex(0, 3'd6, 0, 8'h00, 8'h00));
    applyStimulus("mask_set3",    0, 8'h08, 0, 8'h00, 0, 0, ex(0, 3'd6, 0, 8'h08, 8'h00));
    applyStimulus("mask_hold1",   0, 8'h08, 0, 8'h00, 0, 0, ex(0, 3'd6, 0, 8'h08, 8'h00));
    applyStimulus("mask_hold2",   0, 8'h08, 0, 8'h00, 0, 0, ex(0, 3'd6, 0, 8'h08, 8'h00));
    applyStimulus("mask_wr00",    0, 8'h08, 1, 8'h00, 0, 0, ex(0, 3'd6, 0, 8'h08, 8'h00));
    applyStimulus("mask_irq3",    0, 8'h08, 0, 8'h00, 0, 0, ex(1, 3'd3, 0, 8'h08, 8'h00));
    applyStimulus("mask_inpend",  0, 8'h08, 1, 8'h08, 0, 0, ex(1, 3'd3, 0, 8'h08, 8'h00));
    applyStimulus("mask_ack3",    0, 8'h08, 0, 8'h00, 1, 0, ex(0, 3'd3, 1, 8'h00, 8'h08));
    applyStimulus("mask_eoi3",    0, 8'h00, 0, 8'h00, 0, 1, ex(0, 3'd3, 0, 8'h00, 8'h00));
    applyStimulus("mask_clear",   0, 8'h00, 1, 8'h00, 0, 0, ex(0, 3'd3, 0, 8'h00, 8'h00));

    // Set/clear collision on bit 5
    applyStimulus("coll_set",     0, 8'h20, 0, 8'h00, 0, 0, ex(0, 3'd3, 0, 8'h20, 8'h00));
    applyStimulus("coll_irq5",    0, 8'h20, 0, 8'h00, 0, 0, ex(1, 3'd5, 0, 8'h20, 8'h00));
    applyStimulus("coll_fall",    0, 8'h00, 0, 8'h00, 0, 0, ex(1, 3'd5, 0, 8'h20, 8'h00));
    applyStimulus("coll_ack",     0, 8'h20, 0, 8'h00, 1, 0, ex(0, 3'd5, 1, 8'h20, 8'h20));
    applyStimulus("coll_eoi",     0, 8'h20, 0, 8'h00, 0, 1, ex(0, 3'd5, 0, 8'h20, 8'h00));
    applyStimulus("coll_irq5b",   0, 8'h20, 0, 8'h00, 0, 0, ex(1, 3'd5, 0, 8'h20, 8'h00));
    applyStimulus("coll_ack2",    0, 8'h20, 0, 8'h00, 1, 0, ex(0, 3'd5, 1, 8'h00, 8'h20));
    applyStimulus("coll_eoi2",    0, 8'h00, 0, 8'h00, 0, 1, ex(0, 3'd5, 0, 8'h00, 8'h00));

    // Reset mid-service with a mask that reset must clear
    applyStimulus("rst_set",      0, 8'h07, 0, 8'h00, 0, 0, ex(0, 3'd5, 0, 8'h07, 8'h00));
    applyStimulus("rst_irq2",     0, 8'h07, 0, 8'h00, 0, 0, ex(1, 3'd2, 0, 8'h07, 8'h00));
    applyStimulus("rst_ack2",     0, 8'h07, 0, 8'h00, 1, 0, ex(0, 3'd2, 1, 8'h03, 8'h04));
    applyStimulus("rst_serv",     0, 8'h01, 1, 8'h01, 0, 0, ex(0, 3'd2, 1, 8'h03, 8'h04));
    applyStimulus("rst_pulse",    1, 8'h01, 0, 8'h00, 0, 0, ex(0, 3'd0, 0, 8'h00, 8'h00));
    applyStimulus("rst_edge",     0, 8'h01, 0, 8'h00, 0, 0, ex(0, 3'd0, 0, 8'h01, 8'h00));
    applyStimulus("rst_irq0",     0, 8'h01, 0, 8'h00, 0, 0, ex(1, 3'd0, 0, 8'h01, 8'h00));

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
